// File: rtl/combat_pkg.sv
// Shared types and constants for the combat referee: health width,
// round state encoding, winner codes and the saturating damage helper.
package combat_pkg;

    localparam int HEALTH_W     = 11;
    localparam int REGEN_PERIOD = 30;   // frame_ticks between regeneration steps

    typedef enum logic {
        PLAY = 1'b0,
        KO   = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    // Subtract without wrapping below zero.
    function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                    input logic [HEALTH_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/invuln_timer.sv
// Post-hit invincibility timer for one player. A load arms the counter with
// FRAMES; each tick counts it down unless frozen. active is registered and
// drops on the same edge the count reaches zero. A load wins over a tick.
module invuln_timer #(
    parameter int FRAMES = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    input  logic freeze,
    output logic active
);

    localparam int CNT_W = (FRAMES > 1) ? $clog2(FRAMES + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;

    // Next count and next active flag.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(FRAMES);
        end else if (tick && !freeze && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        active_d = (cnt_d != '0);
    end

    // Counter and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/combat_referee.sv
// Two-player combat referee: edge-detected hits, health bookkeeping,
// invincibility windows and the PLAY/KO round FSM.
// Optional health regeneration is compiled in with `define COMBAT_REGEN_EN.
module combat_referee
    import combat_pkg::*;
#(
    parameter int HEALTH_MAX    = 400,
    parameter int DAMAGE        = 100,
    parameter int INVULN_FRAMES = 60,
    parameter int P2_BAR_X0     = 239
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                p1_hit,
    input  logic                p2_hit,
    input  logic                restart,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic [HEALTH_W-1:0] p2_bar_xpos,
    output logic                p1_invuln,
    output logic                p2_invuln,
    output logic                game_over,
    output logic [1:0]          winner
);

    localparam logic [HEALTH_W-1:0] HMAX = HEALTH_W'(HEALTH_MAX);
    localparam logic [HEALTH_W-1:0] DMG  = HEALTH_W'(DAMAGE);
    localparam logic [HEALTH_W-1:0] BAR0 = HEALTH_W'(P2_BAR_X0);

    state_e              state_q, state_d;
    winner_e             winner_q, winner_d;
    logic [HEALTH_W-1:0] p1_health_q, p1_health_d;
    logic [HEALTH_W-1:0] p2_health_q, p2_health_d;
    logic [HEALTH_W-1:0] bar_q, bar_d;
    logic                game_over_q, game_over_d;
    logic                p1_prev_q, p2_prev_q;
    logic                p1_inv, p2_inv;
    logic                p1_accept, p2_accept;
    logic                restart_go;
    logic                timer_rst_n;
    logic                regen_tick;

    assign restart_go  = (state_q == KO) && restart;
    assign p1_accept   = (state_q == PLAY) && p1_hit && !p1_prev_q && !p1_inv;
    assign p2_accept   = (state_q == PLAY) && p2_hit && !p2_prev_q && !p2_inv;
    // NOTE: the timers' synchronous reset is also driven by a restart from KO; since it is only
    // sampled at the clock edge this clears the counters without an extra port or any async path.
    assign timer_rst_n = rst_n && !restart_go;

    invuln_timer #(.FRAMES(INVULN_FRAMES)) u_p1_timer (
        .clk    (clk),
        .rst_n  (timer_rst_n),
        .load   (p1_accept),
        .tick   (frame_tick),
        .freeze (state_q == KO),
        .active (p1_inv)
    );

    invuln_timer #(.FRAMES(INVULN_FRAMES)) u_p2_timer (
        .clk    (clk),
        .rst_n  (timer_rst_n),
        .load   (p2_accept),
        .tick   (frame_tick),
        .freeze (state_q == KO),
        .active (p2_inv)
    );

`ifdef COMBAT_REGEN_EN
    logic [4:0] div_q, div_d;

    // Shared frame divider: one regeneration strobe every REGEN_PERIOD ticks.
    always_comb begin
        div_d = div_q;
        if (frame_tick) begin
            div_d = (div_q == 5'(REGEN_PERIOD - 1)) ? '0 : div_q + 1'b1;
        end
        regen_tick = frame_tick && (div_q == 5'(REGEN_PERIOD - 1));
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end
`else
    assign regen_tick = 1'b0;
`endif

    // Next-state, health and result logic for the round FSM.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        game_over_d = game_over_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        case (state_q)
            PLAY: begin
                if (p1_accept) begin
                    p1_health_d = sat_sub(p1_health_q, DMG);
                end else if (regen_tick && !p1_inv && (p1_health_q != '0) && (p1_health_q < HMAX)) begin
                    p1_health_d = p1_health_q + 1'b1;
                end
                if (p2_accept) begin
                    p2_health_d = sat_sub(p2_health_q, DMG);
                end else if (regen_tick && !p2_inv && (p2_health_q != '0) && (p2_health_q < HMAX)) begin
                    p2_health_d = p2_health_q + 1'b1;
                end
                if ((p1_health_d == '0) || (p2_health_d == '0)) begin
                    state_d     = KO;
                    game_over_d = 1'b1;
                    if ((p1_health_d == '0) && (p2_health_d == '0)) winner_d = WIN_DRAW;
                    else if (p1_health_d == '0)                     winner_d = WIN_P2;
                    else                                            winner_d = WIN_P1;
                end
            end
            KO: begin
                if (restart) begin
                    state_d     = PLAY;
                    game_over_d = 1'b0;
                    winner_d    = WIN_NONE;
                    p1_health_d = HMAX;
                    p2_health_d = HMAX;
                end
            end
            default: state_d = PLAY;
        endcase
        bar_d = BAR0 + (HMAX - p2_health_d);
    end

    // State, health, result and edge-detect registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= PLAY;
            winner_q    <= WIN_NONE;
            game_over_q <= 1'b0;
            p1_health_q <= HMAX;
            p2_health_q <= HMAX;
            bar_q       <= BAR0;
            p1_prev_q   <= 1'b0;
            p2_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            bar_q       <= bar_d;
            p1_prev_q   <= p1_hit;
            p2_prev_q   <= p2_hit;
        end
    end

    assign p1_health   = p1_health_q;
    assign p2_health   = p2_health_q;
    assign p2_bar_xpos = bar_q;
    assign p1_invuln   = p1_inv;
    assign p2_invuln   = p2_inv;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_combat_referee.sv
// Self-checking bench for combat_referee: directed round scenarios followed by
// randomized play, all compared against a frame-level behavioural model.
// Define COMBAT_REGEN_EN for both bench and RTL to cover regeneration.
module tb_combat_referee;

    localparam int HEALTH_MAX    = 400;
    localparam int DAMAGE        = 100;
    localparam int INVULN_FRAMES = 60;
    localparam int P2_BAR_X0     = 239;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        p1_hit;
    logic        p2_hit;
    logic        restart;
    logic [10:0] p1_health;
    logic [10:0] p2_health;
    logic [10:0] p2_bar_xpos;
    logic        p1_invuln;
    logic        p2_invuln;
    logic        game_over;
    logic [1:0]  winner;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: health, invincibility frames left, round result.
    int m_h[2];
    int m_inv[2];
    int m_prev[2];
    int m_ko;
    int m_win;
    int m_ticks;

    combat_referee #(
        .HEALTH_MAX    (HEALTH_MAX),
        .DAMAGE        (DAMAGE),
        .INVULN_FRAMES (INVULN_FRAMES),
        .P2_BAR_X0     (P2_BAR_X0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .p1_hit      (p1_hit),
        .p2_hit      (p2_hit),
        .restart     (restart),
        .p1_health   (p1_health),
        .p2_health   (p2_health),
        .p2_bar_xpos (p2_bar_xpos),
        .p1_invuln   (p1_invuln),
        .p2_invuln   (p2_invuln),
        .game_over   (game_over),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_h[n]    = HEALTH_MAX;
            m_inv[n]  = 0;
            m_prev[n] = 0;
        end
        m_ko    = 0;
        m_win   = 0;
        m_ticks = 0;
    endtask

    // One clock edge of the game rules.
    task automatic model_edge(input bit tick, input bit h1, input bit h2, input bit rs, input bit rn);
        bit hit[2];
        bit inv_before;
        bit acc;
        hit[0] = h1;
        hit[1] = h2;
        if (!rn) begin
            model_reset();
        end else begin
            if (tick) m_ticks++;
            if (m_ko != 0) begin
                if (rs) begin
                    m_ko  = 0;
                    m_win = 0;
                    for (int n = 0; n < 2; n++) begin
                        m_h[n]   = HEALTH_MAX;
                        m_inv[n] = 0;
                    end
                end
            end else begin
                for (int n = 0; n < 2; n++) begin
                    inv_before = (m_inv[n] > 0);
                    acc = hit[n] && (m_prev[n] == 0) && !inv_before;
                    if (acc) begin
                        m_h[n]   = (m_h[n] > DAMAGE) ? m_h[n] - DAMAGE : 0;
                        m_inv[n] = INVULN_FRAMES;
                    end else begin
                        if (tick && m_inv[n] > 0) m_inv[n]--;
`ifdef COMBAT_REGEN_EN
                        if (tick && (m_ticks % 30 == 0) && !inv_before && m_h[n] > 0 && m_h[n] < HEALTH_MAX)
                            m_h[n]++;
`endif
                    end
                end
                if (m_h[0] == 0 || m_h[1] == 0) begin
                    m_ko  = 1;
                    m_win = (m_h[0] == 0 && m_h[1] == 0) ? 3 : (m_h[0] == 0) ? 2 : 1;
                end
            end
            m_prev[0] = h1;
            m_prev[1] = h2;
        end
    endtask

    task automatic compare_all();
        check("p1_health", int'(p1_health), m_h[0]);
        check("p2_health", int'(p2_health), m_h[1]);
        check("p2_bar_xpos", int'(p2_bar_xpos), P2_BAR_X0 + HEALTH_MAX - m_h[1]);
        check("p1_invuln", int'(p1_invuln), int'(m_inv[0] > 0));
        check("p2_invuln", int'(p2_invuln), int'(m_inv[1] > 0));
        check("game_over", int'(game_over), m_ko);
        check("winner", int'(winner), m_win);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare 1ns later.
    task automatic step(input bit tick, input bit h1, input bit h2, input bit rs, input bit rn);
        frame_tick = tick;
        p1_hit     = h1;
        p2_hit     = h2;
        restart    = rs;
        rst_n      = rn;
        @(posedge clk);
        model_edge(tick, h1, h2, rs, rn);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
    endtask

    task automatic pulse(input bit h1, input bit h2);
        step(0, h1, h2, 0, 1);
        step(0, 0, 0, 0, 1);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 0, 1);
            step(0, 0, 0, 0, 1);
        end
    endtask

    initial begin
        int cnt;
        bit r_h1, r_h2, r_rs;
        frame_tick = 1'b0;
        p1_hit     = 1'b0;
        p2_hit     = 1'b0;
        restart    = 1'b0;
        rst_n      = 1'b0;
        model_reset();

        // Reset values.
        do_reset();
        check("rst_p1_health", int'(p1_health), HEALTH_MAX);
        check("rst_bar", int'(p2_bar_xpos), P2_BAR_X0);
        check("rst_winner", int'(winner), 0);

        // Restart has no effect in PLAY.
        step(1, 0, 0, 1, 1);
        check("play_restart_over", int'(game_over), 0);

        // Single p1 hit: 300 on the next edge, invincible for exactly 60 ticks.
        step(0, 1, 0, 0, 1);
        check("s1_p1_health", int'(p1_health), HEALTH_MAX - DAMAGE);
        check("s1_p1_invuln", int'(p1_invuln), 1);
        step(0, 1, 0, 0, 1);
        check("s1_held_no_retrigger", int'(p1_health), HEALTH_MAX - DAMAGE);
        cnt = 0;
        while (p1_invuln && cnt < 200) begin
            step(1, 0, 0, 0, 1);
            cnt++;
        end
        check("s1_invuln_frames", cnt, INVULN_FRAMES);

        // Second p2 hit inside the invincibility window is ignored.
        do_reset();
        pulse(0, 1);
        frames(10);
        step(0, 0, 1, 0, 1);
        check("s2_p2_health", int'(p2_health), HEALTH_MAX - DAMAGE);
        check("s2_bar", int'(p2_bar_xpos), P2_BAR_X0 + DAMAGE);
        step(0, 0, 0, 0, 1);

        // Four spaced p1 hits: KO, P2 wins.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pulse(1, 0);
            frames(61);
        end
        check("s3_p1_health", int'(p1_health), 0);
        check("s3_game_over", int'(game_over), 1);
        check("s3_winner", int'(winner), 2);

        // In KO a hit is ignored, then restart opens a fresh round.
        pulse(0, 1);
        check("s4_ko_hit_ignored", int'(p2_health), HEALTH_MAX);
        step(0, 0, 0, 1, 1);
        check("s4_p1_health", int'(p1_health), HEALTH_MAX);
        check("s4_p2_health", int'(p2_health), HEALTH_MAX);
        check("s4_winner", int'(winner), 0);
        check("s4_game_over", int'(game_over), 0);
        check("s4_invuln_clr", int'(p1_invuln), 0);
        step(0, 0, 0, 0, 1);

        // Simultaneous hits bring both to 0: draw.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pulse(1, 1);
            frames(61);
        end
        check("s5_p1_100", int'(p1_health), HEALTH_MAX - 3 * DAMAGE);
        step(0, 1, 1, 0, 1);
        check("s5_p1_health", int'(p1_health), 0);
        check("s5_p2_health", int'(p2_health), 0);
        check("s5_winner", int'(winner), 3);

        // Reset overrides a hit and mid-invincibility state.
        do_reset();
        pulse(1, 0);
        step(1, 0, 1, 0, 0);
        check("s6_rst_health", int'(p2_health), HEALTH_MAX);
        check("s6_rst_invuln", int'(p1_invuln), 0);
        step(0, 0, 0, 0, 1);

`ifdef COMBAT_REGEN_EN
        // Regeneration: +3 over 90 ticks once invincibility is over.
        do_reset();
        pulse(1, 0);
        cnt = 0;
        while (p1_invuln && cnt < 200) begin
            step(1, 0, 0, 0, 1);
            cnt++;
        end
        for (int i = 0; i < 90; i++) step(1, 0, 0, 0, 1);
        check("s7_regen", int'(p1_health), HEALTH_MAX - DAMAGE + 3);
`endif

        // Randomized play against the model.
        do_reset();
        r_h1 = 0;
        r_h2 = 0;
        r_rs = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 5) == 0) r_h1 = !r_h1;
            if ($urandom_range(0, 5) == 0) r_h2 = !r_h2;
            r_rs = ($urandom_range(0, 7) == 0);
            step(bit'($urandom_range(0, 1)), r_h1, r_h2, r_rs, ($urandom_range(0, 599) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
